// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the dmem load/store unit.
// Covers request size encodings, store-queue payloads, byte-lane masks and load extension.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    // Byte-lane payload of one queued store.
    typedef struct packed {
        logic [3:0]  wmask;
        logic [31:0] din;
    } sq_data_t;

    // Load/error request held for the single response stage.
    typedef struct packed {
        logic       valid;
        logic       err;
        size_e      size;
        logic       uns;
        logic [1:0] off;
    } mem_req_t;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] off);
        return wdata << {off, 3'b000};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] dout, input size_e size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = dout >> {off, 3'b000};
        case (size)
            SZ_BYTE: return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/lsu_store_queue.sv
// Circular store queue with head/commit/tail pointers: [head,commit) is committed and
// drains one entry per cycle, [commit,tail) is speculative and can be flushed.
module lsu_store_queue
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enq_i,
    input  logic [AW-1:0] enq_waddr_i,
    input  sq_data_t      enq_data_i,
    input  logic          commit_i,
    input  logic          flush_i,
    input  logic [AW-1:0] match_waddr_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          match_o,
    output logic          drain_valid_o,
    output logic [AW-1:0] drain_waddr_o,
    output sq_data_t      drain_data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [PTR_W-1:0] n_committed;
    logic             commit_ok;
    logic [DEPTH-1:0] match_vec;
    logic [AW-1:0]    waddr_q [DEPTH];
    sq_data_t         data_q  [DEPTH];

    assign full_o        = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign empty_o       = head_q == tail_q;
    assign drain_valid_o = head_q != cmt_q;
    assign n_committed   = cmt_q - head_q;
    assign commit_ok     = commit_i && (cmt_q != tail_q);

    assign head_d = head_q + PTR_W'(drain_valid_o);
    assign cmt_d  = cmt_q + PTR_W'(commit_ok);
    assign tail_d = flush_i ? cmt_d : tail_q + PTR_W'(enq_i);

    // Only committed entries take part in the word match; speculative ones are excluded by contract.
    always_comb begin
        logic [IDX_W-1:0] rel;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel          = IDX_W'(i) - head_q[IDX_W-1:0];
            match_vec[i] = ({1'b0, rel} < n_committed) && (waddr_q[i] == match_waddr_i);
        end
    end
    assign match_o = |match_vec;

    assign drain_waddr_o = drain_valid_o ? waddr_q[head_q[IDX_W-1:0]] : '0;
    assign drain_data_o  = drain_valid_o ? data_q[head_q[IDX_W-1:0]]  : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    // NOTE: entry storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            waddr_q[tail_q[IDX_W-1:0]] <= enq_waddr_i;
            data_q[tail_q[IDX_W-1:0]]  <= enq_data_i;
        end
    end

    commit_has_target_a: assert property (@(posedge clk_i) disable iff (reset_i)
        commit_i |-> (cmt_q != tail_q));

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a dual-port dmem macro: stores wait in a committed-drain
// queue, loads read directly and return aligned, extended data one cycle later.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int SQ_DEPTH = 4,
    parameter int TAG_W    = 6,
    parameter int DADDR_W  = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [31:0]        req_addr_i,
    input  logic [1:0]         req_size_i,
    input  logic               req_unsigned_i,
    input  logic [31:0]        req_wdata_i,
    input  logic [TAG_W-1:0]   req_tag_i,
    input  logic               commit_i,
    input  logic               flush_i,
    output logic               resp_valid_o,
    output logic [TAG_W-1:0]   resp_tag_o,
    output logic [31:0]        resp_data_o,
    output logic               resp_err_o,
    output logic               sq_empty_o,
    output logic               dmem_csb_write_o,
    output logic [3:0]         dmem_wmask_o,
    output logic [DADDR_W-1:0] dmem_waddr_o,
    output logic [31:0]        dmem_din_o,
    output logic               dmem_csb_read_o,
    output logic [DADDR_W-1:0] dmem_raddr_o,
    input  logic [31:0]        dmem_dout_i
);

    logic [DADDR_W-1:0] req_waddr;
    logic [1:0]         req_off;
    size_e              req_size;
    logic               req_err, accept, store_enq, load_issue;
    logic               sq_full, sq_match, drain_valid;
    sq_data_t           enq_data, drain_data;
    mem_req_t           s1_d, s1_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic               unused_addr_bits;

    assign req_waddr        = req_addr_i[DADDR_W+1:2];
    assign req_off          = req_addr_i[1:0];
    assign unused_addr_bits = ^req_addr_i[31:DADDR_W+2];
    assign req_size         = size_e'(req_size_i);
    assign req_err          = is_misaligned(req_size, req_off);

    // Error requests never touch dmem, so only flush/reset can hold them off.
    always_comb begin
        req_ready_o = 1'b0;
        if (!reset_i && !flush_i) begin
            if (req_err)       req_ready_o = 1'b1;
            else if (req_we_i) req_ready_o = !sq_full;
            else               req_ready_o = !sq_match;
        end
    end

    assign accept     = req_valid_i && req_ready_o;
    assign store_enq  = accept && req_we_i && !req_err;
    assign load_issue = accept && !req_we_i && !req_err;

    assign enq_data.wmask = lane_mask(req_size, req_off);
    assign enq_data.din   = lane_data(req_wdata_i, req_off);

    assign dmem_csb_read_o = !load_issue;
    assign dmem_raddr_o    = load_issue ? req_waddr : '0;

    always_comb begin
        s1_d       = '0;
        s1_d.valid = accept && (req_err || !req_we_i);
        s1_d.err   = req_err;
        s1_d.size  = req_size;
        s1_d.uns   = req_unsigned_i;
        s1_d.off   = req_off;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q     <= '0;
            s1_tag_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s1_tag_q <= req_tag_i;
        end
    end

    assign resp_valid_o = s1_q.valid && !flush_i;
    assign resp_err_o   = resp_valid_o && s1_q.err;
    assign resp_tag_o   = resp_valid_o ? s1_tag_q : '0;
    assign resp_data_o  = (resp_valid_o && !s1_q.err)
                        ? load_extend(dmem_dout_i, s1_q.size, s1_q.off, s1_q.uns) : '0;

    lsu_store_queue #(
        .DEPTH (SQ_DEPTH),
        .AW    (DADDR_W)
    ) u_sq (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .enq_i         (store_enq),
        .enq_waddr_i   (req_waddr),
        .enq_data_i    (enq_data),
        .commit_i      (commit_i),
        .flush_i       (flush_i),
        .match_waddr_i (req_waddr),
        .full_o        (sq_full),
        .empty_o       (sq_empty_o),
        .match_o       (sq_match),
        .drain_valid_o (drain_valid),
        .drain_waddr_o (dmem_waddr_o),
        .drain_data_o  (drain_data)
    );

    assign dmem_csb_write_o = !drain_valid;
    assign dmem_wmask_o     = drain_data.wmask;
    assign dmem_din_o       = drain_data.din;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: stimulus pushes expected responses and dmem writes,
// two negedge monitors pop and compare whatever the DUT presents.
module tb_dmem_lsu;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic [5:0]  req_tag_i;
    logic        commit_i, flush_i;
    logic        resp_valid_o, resp_err_o, sq_empty_o;
    logic [5:0]  resp_tag_o;
    logic [31:0] resp_data_o;
    logic        dmem_csb_write_o, dmem_csb_read_o;
    logic [3:0]  dmem_wmask_o;
    logic [7:0]  dmem_waddr_o, dmem_raddr_o;
    logic [31:0] dmem_din_o, dmem_dout_i;

    dmem_lsu #(.SQ_DEPTH(4), .TAG_W(6), .DADDR_W(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
        .commit_i(commit_i), .flush_i(flush_i),
        .resp_valid_o(resp_valid_o), .resp_tag_o(resp_tag_o), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o), .sq_empty_o(sq_empty_o),
        .dmem_csb_write_o(dmem_csb_write_o), .dmem_wmask_o(dmem_wmask_o),
        .dmem_waddr_o(dmem_waddr_o), .dmem_din_o(dmem_din_o),
        .dmem_csb_read_o(dmem_csb_read_o), .dmem_raddr_o(dmem_raddr_o),
        .dmem_dout_i(dmem_dout_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // SRAM model: masked write on port 0, 1-cycle read on port 1, plus a preload port.
    bit [31:0] mem [256];
    bit [31:0] sram_dout;
    logic       pl_en = 1'b0;
    logic [7:0] pl_idx = '0;
    logic [31:0] pl_data = '0;
    assign dmem_dout_i = sram_dout;

    always @(posedge clk_i) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        if (!dmem_csb_write_o)
            for (int b = 0; b < 4; b++)
                if (dmem_wmask_o[b]) mem[dmem_waddr_o][8*b +: 8] <= dmem_din_o[8*b +: 8];
        if (!dmem_csb_read_o) sram_dout <= mem[dmem_raddr_o];
    end

    typedef struct { logic [5:0] tag; logic [31:0] data; logic err; int cyc; } resp_t;
    typedef struct { logic [7:0] waddr; logic [3:0] mask; logic [31:0] din; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor.
    resp_t r;
    always @(negedge clk_i) begin
        if (!reset_i && resp_valid_o) begin
            if (resp_q.size() == 0) check("unexpected_resp", {31'b0, resp_valid_o}, 32'd0);
            else begin
                r = resp_q.pop_front();
                check("resp_tag",  {26'b0, resp_tag_o}, {26'b0, r.tag});
                check("resp_data", resp_data_o, r.data);
                check("resp_err",  {31'b0, resp_err_o}, {31'b0, r.err});
                check("resp_cycle", cyc, r.cyc);
            end
        end
    end

    // dmem write monitor.
    wr_t w;
    always @(negedge clk_i) begin
        if (!reset_i && !dmem_csb_write_o) begin
            if (wr_q.size() == 0) check("unexpected_write", {31'b0, dmem_csb_write_o}, 32'd1);
            else begin
                w = wr_q.pop_front();
                check("wr_waddr", {24'b0, dmem_waddr_o}, {24'b0, w.waddr});
                check("wr_mask",  {28'b0, dmem_wmask_o}, {28'b0, w.mask});
                check("wr_din",   dmem_din_o, w.din);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        step();
        pl_en = 1'b0;
    endtask

    task automatic expect_write(input logic [7:0] waddr, input logic [3:0] mask, input logic [31:0] din);
        wr_t e;
        e.waddr = waddr; e.mask = mask; e.din = din;
        wr_q.push_back(e);
    endtask

    task automatic commit_pulse();
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
    endtask

    // Issue one request, waiting a bounded number of cycles for ready.
    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input logic [5:0] tag,
                        input logic exp_err, input logic [31:0] exp_data,
                        input string name, output int waited);
        resp_t e;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_size_i = size;
        req_unsigned_i = uns; req_wdata_i = wdata; req_tag_i = tag;
        waited = 0;
        @(negedge clk_i);
        while (!req_ready_o && waited < 20) begin
            waited++;
            @(negedge clk_i);
        end
        check({name, "_ready"}, {31'b0, req_ready_o}, 32'd1);
        if (req_ready_o) begin
            if (!we || exp_err) begin
                e.tag = tag; e.data = exp_data; e.err = exp_err; e.cyc = cyc + 1;
                resp_q.push_back(e);
            end
            if (we || exp_err) check({name, "_csb_read"}, {31'b0, dmem_csb_read_o}, 32'd1);
            else begin
                check({name, "_csb_read"}, {31'b0, dmem_csb_read_o}, 32'd0);
                check({name, "_raddr"}, {24'b0, dmem_raddr_o}, {24'b0, addr[9:2]});
            end
        end
        step();
        req_valid_i = 1'b0;
    endtask

    int wt;

    initial begin
        reset_i = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h10; req_size_i = 2'd2;
        req_unsigned_i = 1'b0; req_wdata_i = '0; req_tag_i = '0;
        commit_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready",     {31'b0, req_ready_o}, 32'd0);
        check("rst_sq_empty",  {31'b0, sq_empty_o}, 32'd1);
        check("rst_csb_write", {31'b0, dmem_csb_write_o}, 32'd1);
        check("rst_csb_read",  {31'b0, dmem_csb_read_o}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
        check("rst_resp_data", resp_data_o, 32'd0);
        check("rst_resp_tag",  {26'b0, resp_tag_o}, 32'd0);
        check("rst_wmask",     {28'b0, dmem_wmask_o}, 32'd0);
        check("rst_addrs",     {16'b0, dmem_waddr_o, dmem_raddr_o}, 32'd0);
        check("rst_din",       dmem_din_o, 32'd0);
        req_valid_i = 1'b0;
        reset_i = 1'b0;
        step();

        // Loads and extension.
        preload(8'd4, 32'hDEADBEEF);
        send(1'b0, 32'h10, 2'd2, 1'b0, '0, 6'd5, 1'b0, 32'hDEADBEEF, "lw_10", wt);
        preload(8'd4, 32'h80FF0000);
        send(1'b0, 32'h13, 2'd0, 1'b0, '0, 6'd6,  1'b0, 32'hFFFFFF80, "lb_13",  wt);
        send(1'b0, 32'h13, 2'd0, 1'b1, '0, 6'd7,  1'b0, 32'h00000080, "lbu_13", wt);
        send(1'b0, 32'h12, 2'd1, 1'b1, '0, 6'd8,  1'b0, 32'h000080FF, "lhu_12", wt);
        send(1'b0, 32'h12, 2'd1, 1'b0, '0, 6'd9,  1'b0, 32'hFFFF80FF, "lh_12",  wt);
        send(1'b0, 32'h12, 2'd0, 1'b0, '0, 6'd10, 1'b0, 32'hFFFFFFFF, "lb_12",  wt);

        // Half store, commit, drain on the following cycle.
        expect_write(8'd8, 4'b1100, 32'hABCD0000);
        send(1'b1, 32'h22, 2'd1, 1'b0, 32'h0000ABCD, 6'd11, 1'b0, '0, "sh_22", wt);
        check("sq_not_empty", {31'b0, sq_empty_o}, 32'd0);
        commit_pulse();
        @(negedge clk_i);
        check("drain_csb_write", {31'b0, dmem_csb_write_o}, 32'd0);
        check("drain_waddr", {24'b0, dmem_waddr_o}, 32'd8);
        check("drain_wmask", {28'b0, dmem_wmask_o}, 32'hC);
        check("drain_din", dmem_din_o, 32'hABCD0000);
        step();
        check("sq_empty_after_drain", {31'b0, sq_empty_o}, 32'd1);
        send(1'b0, 32'h20, 2'd2, 1'b0, '0, 6'd12, 1'b0, 32'hABCD0000, "lw_20",  wt);
        send(1'b0, 32'h22, 2'd1, 1'b1, '0, 6'd13, 1'b0, 32'h0000ABCD, "lhu_22", wt);

        // Fill with speculative stores, check back-pressure, then flush.
        for (int i = 0; i < 4; i++)
            send(1'b1, 32'h40 + i, 2'd0, 1'b0, 32'h11 * (i + 1), 6'(20 + i), 1'b0, '0, "sb_fill", wt);
        check("sq_full_not_empty", {31'b0, sq_empty_o}, 32'd0);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h44; req_size_i = 2'd0;
        @(negedge clk_i);
        check("full_ready", {31'b0, req_ready_o}, 32'd0);
        flush_i = 1'b1;
        #1;
        check("flush_ready", {31'b0, req_ready_o}, 32'd0);
        step();
        flush_i = 1'b0; req_valid_i = 1'b0;
        check("flush_sq_empty", {31'b0, sq_empty_o}, 32'd1);
        repeat (3) step();
        send(1'b0, 32'h40, 2'd2, 1'b0, '0, 6'd24, 1'b0, 32'h00000000, "lw_40_flushed", wt);

        // Committed same-word store stalls a load until it drains.
        expect_write(8'd5, 4'b1111, 32'h11223344);
        send(1'b1, 32'h14, 2'd2, 1'b0, 32'h11223344, 6'd25, 1'b0, '0, "sw_14", wt);
        commit_pulse();
        send(1'b0, 32'h14, 2'd2, 1'b0, '0, 6'd26, 1'b0, 32'h11223344, "lw_14_stall", wt);
        check("stall_cycles", wt, 1);

        // Error requests.
        send(1'b0, 32'h02, 2'd2, 1'b0, '0, 6'd30, 1'b1, 32'd0, "lw_misaligned", wt);
        send(1'b0, 32'h08, 2'd3, 1'b0, '0, 6'd31, 1'b1, 32'd0, "size3", wt);
        send(1'b1, 32'h05, 2'd1, 1'b0, 32'h1234, 6'd32, 1'b1, 32'd0, "sh_odd", wt);
        check("err_store_no_entry", {31'b0, sq_empty_o}, 32'd1);

        // Flush in the response cycle suppresses the load response.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h10; req_size_i = 2'd2; req_tag_i = 6'd33;
        @(negedge clk_i);
        check("flushload_ready", {31'b0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_resp_valid", {31'b0, resp_valid_o}, 32'd0);
        step();
        flush_i = 1'b0;

        // Reset with a committed store pending: it must never reach dmem.
        send(1'b1, 32'h30, 2'd2, 1'b0, 32'hCAFEF00D, 6'd34, 1'b0, '0, "sw_30", wt);
        commit_pulse();
        reset_i = 1'b1;
        #1;
        check("midrst_csb_write", {31'b0, dmem_csb_write_o}, 32'd1);
        check("midrst_sq_empty", {31'b0, sq_empty_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        step();
        send(1'b0, 32'h30, 2'd2, 1'b0, '0, 6'd35, 1'b0, 32'h00000000, "lw_30_after_rst", wt);

        repeat (3) step();
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("wr_q_drained", wr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
